// File: rtl/iq_mixer_dec_pkg.sv
// Shared width derivations, decimation clamp and round/saturate classification for the I/Q mixer.
// Pure declarations: no logic, no latency, no flow control.
package mixer_pkg;

  typedef enum logic [1:0] {
    RS_PASS   = 2'd0,
    RS_SAT_HI = 2'd1,
    RS_SAT_LO = 2'd2
  } rs_mode_e;

  function automatic int calc_pw(input int dw, input int nw);
    return dw + nw;
  endfunction

  // Summing up to dmax full-scale products needs clog2(dmax) guard bits.
  function automatic int calc_aw(input int dw, input int nw, input int dmax);
    return dw + nw + $clog2(dmax);
  endfunction

  function automatic int unsigned eff_decim(input int unsigned d, input int unsigned dmax);
    if (d == 0) return 1;
    if (d > dmax) return dmax;
    return d;
  endfunction

endpackage

// File: rtl/iq_round_sat.sv
// Combinational rounding arithmetic right shift of an accumulator sum, clamped to OW bits.
// Zero latency, no flow control; sat flags any clamp.
module iq_round_sat
  import mixer_pkg::*;
#(
  parameter int AW  = 24,
  parameter int OW  = 16,
  parameter int SHW = 5
) (
  input  logic signed [AW-1:0]  din,
  input  logic        [SHW-1:0] shift,
  output logic signed [OW-1:0]  dout,
  output logic                  sat
);

  // Wide enough that the rounding bias for the largest shift never overflows.
  localparam int XW = AW + (1 << SHW);
  localparam logic signed [XW-1:0] MAX_V = (XW'(1) <<< (OW - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MIN_V = -(XW'(1) <<< (OW - 1));

  logic signed [XW-1:0] bias;
  logic signed [XW-1:0] x;
  logic signed [XW-1:0] r;
  rs_mode_e             mode;

  always_comb begin
    bias = (shift == '0) ? '0 : (XW'(1) <<< (shift - 1'b1));
    x    = XW'(din) + bias;
    r    = x >>> shift;
    mode = RS_PASS;
    if (r > MAX_V) begin
      mode = RS_SAT_HI;
    end else if (r < MIN_V) begin
      mode = RS_SAT_LO;
    end
    case (mode)
      RS_SAT_HI: dout = OW'(MAX_V);
      RS_SAT_LO: dout = OW'(MIN_V);
      default:   dout = OW'(r);
    endcase
    sat = (mode != RS_PASS);
  end

endmodule

// File: rtl/iq_mixer_dec.sv
// Quadrature mixer with integrate-and-dump decimation, rounding shift and saturation.
// out_valid 4 clk after the last sample of a group; valid-qualified, no backpressure.
module iq_mixer_dec
  import mixer_pkg::*;
#(
  parameter  int DW        = 8,
  parameter  int NW        = 8,
  parameter  int OW        = 16,
  parameter  int DECIM_MAX = 256,
  parameter  int SHW       = 5,
  localparam int PW        = calc_pw(DW, NW),
  localparam int CW        = $clog2(DECIM_MAX + 1),
  localparam int AW        = calc_aw(DW, NW, DECIM_MAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] adc_data,
  input  logic signed [NW-1:0] nco_sin,
  input  logic signed [NW-1:0] nco_cos,
  input  logic        [CW-1:0] decim,
  input  logic       [SHW-1:0] shift,
  output logic                 out_valid,
  output logic signed [OW-1:0] I_out,
  output logic signed [OW-1:0] Q_out,
  output logic                 sat_flag
);

  logic                 v1_q, v1_d;
  logic signed [DW-1:0] a1_q, a1_d;
  logic signed [NW-1:0] c1_q, c1_d, s1_q, s1_d;

  logic                 v2_q, v2_d;
  logic signed [PW-1:0] pi2_q, pi2_d, pq2_q, pq2_d;

  logic        [CW-1:0] cnt_q, cnt_d, dec_q, dec_d;
  logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [AW-1:0] dump_i_q, dump_i_d, dump_q_q, dump_q_d;
  logic                 v3_q, v3_d;

  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic                 sat_flag_q, sat_flag_d;

  logic        [CW-1:0] dec_eff, grp_dec;
  logic signed [AW-1:0] p_i_ext, p_q_ext;
  logic signed [OW-1:0] i_rs, q_rs;
  logic                 sat_i, sat_q;

  // S1/S2: capture inputs, then form full-precision products.
  always_comb begin
    v1_d  = in_valid & ~clr;
    a1_d  = a1_q;
    c1_d  = c1_q;
    s1_d  = s1_q;
    if (in_valid) begin
      a1_d = adc_data;
      c1_d = nco_cos;
      s1_d = nco_sin;
    end
    v2_d  = v1_q & ~clr;
    pi2_d = a1_q * c1_q;
    pq2_d = a1_q * s1_q;
  end

  // S3: group accumulator; decimation factor is latched only at group start.
  always_comb begin
    dec_eff  = CW'(eff_decim(32'(decim), DECIM_MAX));
    grp_dec  = (cnt_q == '0) ? dec_eff : dec_q;
    p_i_ext  = AW'(pi2_q);
    p_q_ext  = AW'(pq2_q);
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    dump_i_d = dump_i_q;
    dump_q_d = dump_q_q;
    v3_d     = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (v2_q) begin
      if (cnt_q == '0) begin
        acc_i_d = p_i_ext;
        acc_q_d = p_q_ext;
        dec_d   = dec_eff;
      end else begin
        acc_i_d = acc_i_q + p_i_ext;
        acc_q_d = acc_q_q + p_q_ext;
      end
      if (cnt_q == grp_dec - 1'b1) begin
        dump_i_d = acc_i_d;
        dump_q_d = acc_q_d;
        v3_d     = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  iq_round_sat #(.AW(AW), .OW(OW), .SHW(SHW)) u_rs_i (
    .din   (dump_i_q),
    .shift (shift),
    .dout  (i_rs),
    .sat   (sat_i)
  );

  iq_round_sat #(.AW(AW), .OW(OW), .SHW(SHW)) u_rs_q (
    .din   (dump_q_q),
    .shift (shift),
    .dout  (q_rs),
    .sat   (sat_q)
  );

  always_comb begin
    out_valid_d = v3_q & ~clr;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    sat_flag_d  = sat_flag_q;
    if (clr) begin
      sat_flag_d = 1'b0;
    end else if (v3_q) begin
      i_out_d    = i_rs;
      q_out_d    = q_rs;
      sat_flag_d = sat_flag_q | sat_i | sat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      a1_q        <= '0;
      c1_q        <= '0;
      s1_q        <= '0;
      v2_q        <= 1'b0;
      pi2_q       <= '0;
      pq2_q       <= '0;
      cnt_q       <= '0;
      dec_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      dump_i_q    <= '0;
      dump_q_q    <= '0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      c1_q        <= c1_d;
      s1_q        <= s1_d;
      v2_q        <= v2_d;
      pi2_q       <= pi2_d;
      pq2_q       <= pq2_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      dump_i_q    <= dump_i_d;
      dump_q_q    <= dump_q_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign I_out     = i_out_q;
  assign Q_out     = q_out_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_iq_mixer_dec.sv
// Scoreboard bench for iq_mixer_dec: an arithmetic group model predicts each strobe,
// a negedge monitor pops and compares value, timing and sticky saturation.
module tb_iq_mixer_dec;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic signed [7:0] adc_data, nco_sin, nco_cos;
  logic        [8:0] decim;
  logic        [4:0] shift;
  logic              out_valid;
  logic signed [15:0] I_out, Q_out;
  logic              sat_flag;

  iq_mixer_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .adc_data  (adc_data),
    .nco_sin   (nco_sin),
    .nco_cos   (nco_cos),
    .decim     (decim),
    .shift     (shift),
    .out_valid (out_valid),
    .I_out     (I_out),
    .Q_out     (Q_out),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int i;
    int q;
    bit sat;
  } exp_t;
  exp_t sbq[$];

  longint m_sum_i, m_sum_q;
  int     m_cnt = 0;
  int     m_dec = 1;
  bit     m_sat = 0;
  int     last_start = -100;
  int     mon_i = 0, mon_q = 0;
  bit     mon_sat = 0;

  function automatic int eff(input int d);
    if (d == 0) return 1;
    if (d > 256) return 256;
    return d;
  endfunction

  function automatic void rs_model(input longint s, input int sh, output int v, output bit sat);
    longint r;
    r = s + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
    r = r >>> sh;
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1'b1;
    end
    v = int'(r);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_sum_i = 0;
    m_sum_q = 0;
    m_sat   = 0;
  endtask

  // One input cycle; the model adds the sample to the current group and
  // predicts a strobe 4 clocks later when the group completes.
  task automatic send(input bit v, input int a, input int c, input int s);
    exp_t e;
    int   vi, vq;
    bit   si, sq;
    in_valid = v;
    adc_data = a[7:0];
    nco_cos  = c[7:0];
    nco_sin  = s[7:0];
    if (v) begin
      if (m_cnt == 0) begin
        m_dec      = eff(int'(decim));
        m_sum_i    = 0;
        m_sum_q    = 0;
        last_start = cyc;
      end
      m_sum_i += longint'(a * c);
      m_sum_q += longint'(a * s);
      m_cnt++;
      if (m_cnt == m_dec) begin
        rs_model(m_sum_i, int'(shift), vi, si);
        rs_model(m_sum_q, int'(shift), vq, sq);
        m_sat = m_sat | si | sq;
        e.cyc = cyc + 4;
        e.i   = vi;
        e.q   = vq;
        e.sat = m_sat;
        sbq.push_back(e);
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 0, 0, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
    mon_sat = 1'b0;
  endtask

  task automatic do_rst(input string name);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check({name, "_rst_I"}, I_out, 0);
    check({name, "_rst_Q"}, Q_out, 0);
    check({name, "_rst_vld"}, out_valid, 0);
    check({name, "_rst_sat"}, sat_flag, 0);
    model_reset();
    mon_i = 0;
    mon_q = 0;
    mon_sat = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [8:0] pick_decim();
    case ($urandom_range(0, 7))
      0: return 9'd0;
      1: return 9'd1;
      2: return 9'd2;
      3: return 9'd3;
      4: return 9'd4;
      5: return 9'd5;
      6: return 9'd8;
      default: return 9'd300;
    endcase
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got out_valid=1 expected 0 (cyc %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          check("strobe_cyc", cyc, e.cyc);
          check("strobe_I", I_out, e.i);
          check("strobe_Q", Q_out, e.q);
          check("strobe_sat", sat_flag, e.sat);
          mon_i   = e.i;
          mon_q   = e.q;
          mon_sat = e.sat;
        end
      end else begin
        check("hold_I", I_out, mon_i);
        check("hold_Q", Q_out, mon_q);
        check("hold_sat", sat_flag, mon_sat);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    adc_data = '0;
    nco_sin  = '0;
    nco_cos  = '0;
    decim    = 9'd1;
    shift    = 5'd0;
    #12;
    check("reset_I", I_out, 0);
    check("reset_Q", Q_out, 0);
    check("reset_vld", out_valid, 0);
    check("reset_sat", sat_flag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // full-rate single sample
    decim = 9'd1;
    shift = 5'd0;
    send(1'b1, 100, 127, -128);
    idle(6);
    check("t1_I", I_out, 12700);
    check("t1_Q", Q_out, -12800);

    decim = 9'd4;
    send(1'b1, 10, 1, -1);
    send(1'b1, 20, 1, -1);
    send(1'b1, 30, 1, -1);
    send(1'b1, 40, 1, -1);
    idle(6);
    check("t2_I", I_out, 100);
    check("t2_Q", Q_out, -100);

    repeat (4) send(1'b1, -128, -128, 0);
    idle(6);
    check("t3_I", I_out, 32767);
    check("t3_sat", sat_flag, 1);

    decim = 9'd1;
    shift = 5'd2;
    send(1'b1, 6, 1, 0);
    idle(6);
    check("t4_pos_I", I_out, 2);
    send(1'b1, -6, 1, 0);
    idle(6);
    check("t4_neg_I", I_out, -1);
    shift = 5'd0;
    decim = 9'd2;
    send(1'b1, -128, 127, 0);
    send(1'b1, -128, 1, 0);
    idle(6);
    check("t4_exact_I", I_out, -16384);
    check("t4_sat_sticky", sat_flag, 1);

    // gaps inside a group; decim change mid-group waits for next group
    decim = 9'd3;
    send(1'b1, 7, 2, 3);
    idle(2);
    decim = 9'd2;
    send(1'b1, -5, 2, 3);
    idle(1);
    send(1'b1, 9, 2, 3);
    idle(6);
    check("t5_I", I_out, 22);
    check("t5_Q", Q_out, 33);
    send(1'b1, 1, 4, 0);
    send(1'b1, 2, 4, 0);
    idle(6);
    check("t5_next_I", I_out, 12);

    do_clr();
    check("t6_clr_sat", sat_flag, 0);
    decim = 9'd4;
    send(1'b1, 3, 1, 0);
    send(1'b1, 3, 1, 0);
    do_clr();
    repeat (4) send(1'b1, 5, 1, 0);
    idle(6);
    check("t6_clr_I", I_out, 20);
    send(1'b1, 3, 1, 0);
    send(1'b1, 3, 1, 0);
    do_rst("t6");
    repeat (4) send(1'b1, 5, 1, 0);
    idle(6);
    check("t6_rst_I", I_out, 20);

    for (int it = 0; it < 40; it++) begin
      idle(8);
      if ($urandom_range(0, 3) == 0) do_clr();
      shift = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 6)) : 5'($urandom_range(0, 31));
      for (int n = 0; n < 40; n++) begin
        // decim is read three cycles after a group-start sample
        if (cyc >= last_start + 3 && $urandom_range(0, 3) == 0) decim = pick_decim();
        if ($urandom_range(0, 3) == 0) idle(1);
        else send(1'b1, rnd8(), rnd8(), rnd8());
      end
    end
    idle(8);
    check("pending_strobes", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
